// File: rtl/pe_packet_unpacker_if.sv
// Router-to-unpacker packet handshake and
// unpacker-to-scratchpad word handshake.
interface pe_packet_unpacker_if #(
  parameter int PKT_W = 57,
  parameter int AW    = 3,
  parameter int WIDTH = 8
);
  logic             pkt_valid;
  logic             pkt_ready;
  logic [PKT_W-1:0] pkt_data;
  logic             wr_valid;
  logic             wr_ready;
  logic             wr_sel;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport slave (
    input  pkt_valid, pkt_data, wr_ready,
    output pkt_ready, wr_valid, wr_sel,
    output wr_addr, wr_data
  );

  modport master (
    output pkt_valid, pkt_data, wr_ready,
    input  pkt_ready, wr_valid, wr_sel,
    input  wr_addr, wr_data
  );
endinterface

// File: rtl/pe_packet_unpacker.sv
// PE receive side: NoC packet -> byte writes into ifmap/filter spads.
// Define PKT_DST_CHECK_EN to drop packets not addressed to NODE_ADDR.
module pe_packet_unpacker #(
  parameter int         PKT_W     = 57,
  parameter int         DATA_W    = 40,
  parameter int         WIDTH     = 8,
  parameter int         DEPTH_I   = 5,
  parameter int         ADDR_I    = 3,
  parameter int         DEPTH_F   = 5,
  parameter int         ADDR_F    = 3,
  parameter logic [3:0] NODE_ADDR = 4'h2
) (
  input  logic clk,
  input  logic reset,
  pe_packet_unpacker_if.slave bus,
  input  logic clear,
  output logic ifmap_loaded,
  output logic filter_loaded,
  output logic pkt_err
);
  localparam int AW = (ADDR_I > ADDR_F) ? ADDR_I : ADDR_F;
  localparam int NB = DATA_W / WIDTH;
  localparam logic [ADDR_I-1:0] LAST_I = ADDR_I'(DEPTH_I - 1);
  localparam logic [ADDR_F-1:0] LAST_F = ADDR_F'(DEPTH_F - 1);

  typedef enum logic {IDLE, UNPACK} state_t;

  typedef struct packed {
    logic [3:0]        dst;
    logic [3:0]        src;
    logic [1:0]        hop;
    logic [2:0]        kind;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] payload;
  } pkt_t;

  logic [PKT_W-1:0]  raw;
  pkt_t              pkt;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] payload_q;
  logic              sel_q;
  logic [2:0]        rem_q;
  logic              ready_q;
  logic              err_q;
  logic [ADDR_I-1:0] ptr_i_q;
  logic [ADDR_F-1:0] ptr_f_q;
  logic              ld_i_q, ld_f_q;
  logic              wr_valid;
  logic              accept, word, last;
  logic              good, dst_ok;
  logic              unused_ok;

  assign raw = bus.pkt_data;
  assign pkt = raw;

`ifdef PKT_DST_CHECK_EN
  assign dst_ok    = (pkt.dst == NODE_ADDR);
  assign unused_ok = ^{pkt.src, pkt.hop};
`else
  assign dst_ok    = 1'b1;
  assign unused_ok = ^{pkt.src, pkt.hop, pkt.dst, NODE_ADDR};
`endif

  assign good = (pkt.kind == 3'd0 || pkt.kind == 3'd1)
             && (pkt.cnt != 4'd0)
             && (pkt.cnt <= 4'(NB))
             && dst_ok;

  assign wr_valid = (state_q == UNPACK);
  assign accept   = bus.pkt_valid && ready_q;
  assign word     = wr_valid && bus.wr_ready;
  assign last     = (rem_q == 3'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && good) state_d = UNPACK;
      UNPACK:  if (word && last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      payload_q <= '0;
      sel_q     <= 1'b0;
      rem_q     <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      err_q   <= accept && !good;
      if (accept && good) begin
        payload_q <= pkt.payload;
        sel_q     <= pkt.kind[0];
        rem_q     <= pkt.cnt[2:0];
      end else if (word) begin
        payload_q <= payload_q >> WIDTH;
        rem_q     <= rem_q - 3'd1;
      end
    end
  end

  // clear outranks a wrap landing on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_i_q <= '0;
      ptr_f_q <= '0;
      ld_i_q  <= 1'b0;
      ld_f_q  <= 1'b0;
    end else if (clear) begin
      ptr_i_q <= '0;
      ptr_f_q <= '0;
      ld_i_q  <= 1'b0;
      ld_f_q  <= 1'b0;
    end else if (word) begin
      if (sel_q) begin
        if (ptr_f_q == LAST_F) begin
          ptr_f_q <= '0;
          ld_f_q  <= 1'b1;
        end else begin
          ptr_f_q <= ptr_f_q + 1'b1;
        end
      end else begin
        if (ptr_i_q == LAST_I) begin
          ptr_i_q <= '0;
          ld_i_q  <= 1'b1;
        end else begin
          ptr_i_q <= ptr_i_q + 1'b1;
        end
      end
    end
  end

  assign bus.pkt_ready = ready_q;
  assign bus.wr_valid  = wr_valid;
  assign bus.wr_sel    = sel_q;
  assign bus.wr_addr   = sel_q ? AW'(ptr_f_q) : AW'(ptr_i_q);
  assign bus.wr_data   = payload_q[WIDTH-1:0];
  assign ifmap_loaded  = ld_i_q;
  assign filter_loaded = ld_f_q;
  assign pkt_err       = err_q;
endmodule
